// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   First-word-fall-through receive buffer that sits directly behind the UART
//   receiver. It stores each received word together with its parity-pass flag
//   and hands the words to a consumer over a valid/ready port. Words that
//   arrive while the buffer is full are dropped, and a sticky overflow flag
//   records the loss.
//
// Parameters
//   DATA_WIDTH   received word width (1..8)
//   DEPTH        number of entries (power of two, >= 2)
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-low reset
//   in_vld       receiver word valid
//   in_data      receiver word
//   in_pc_pass   receiver parity check passed
//   in_rdy       accept strobe to the receiver (registered 1 out of reset)
//   out_vld      head entry valid
//   out_data     head word
//   out_pc_pass  parity flag stored with the head word
//   out_rdy      consumer pops the head when out_vld && out_rdy
//   count        occupancy, 0..DEPTH
//   full         count == DEPTH
//   empty        count == 0
//   overflow     sticky: a word was dropped because the buffer was full
//   overflow_clr synchronous clear of overflow (a same-cycle drop wins)
//
// Build option
//   UART_RX_FIFO_DROP_BAD_EN  when defined, words with in_pc_pass=0 are
//                             accepted but discarded, and out_pc_pass is 1.
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_pc_pass,
  output logic                         in_rdy,
  output logic                         out_vld,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_pc_pass,
  input  logic                         out_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  input  logic                         overflow_clr
);

  localparam int AW = $clog2(DEPTH);     // entry index width
  localparam int PW = AW + 1;            // pointer width incl. wrap bit
  localparam int CW = $clog2(DEPTH + 1); // occupancy width
  localparam int EW = DATA_WIDTH + 1;    // {pc_pass, data}

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 8) begin : g_bad_width
      $fatal(1, "uart_rx_fifo: DATA_WIDTH must be 1..8");
    end
  endgenerate

  logic [EW-1:0]  mem [DEPTH];

  logic           in_rdy_q;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           ovf_q, ovf_d;

  logic           push;
  logic           store_req;
  logic           pop;
  logic           wr_en;
  logic           drop;
  logic [EW-1:0]  wr_entry;
  logic [EW-1:0]  head;
  logic           ptr_empty;
  logic           ptr_full;

  // The receiver cannot stall, so in_rdy never drops after reset release.
  assign push = in_vld && in_rdy_q;

`ifdef UART_RX_FIFO_DROP_BAD_EN
  // Bad-parity words are handshaken but never reach storage.
  assign store_req = push && in_pc_pass;
  assign wr_entry  = {1'b1, in_data};
`else
  assign store_req = push;
  assign wr_entry  = {in_pc_pass, in_data};
`endif

  // out_vld is !empty_q, so a word pushed into an empty buffer cannot be
  // popped in the same cycle.
  assign pop   = !empty_q && out_rdy;
  // A full buffer still takes a word when the head leaves on the same edge.
  assign wr_en = store_req && (!full_q || pop);
  assign drop  = store_req && full_q && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    // Set has priority over clear.
    ovf_d = ovf_q;
    if (drop)              ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
  end

  // Pointer-derived status, cross-checked against the count-derived flags.
  assign ptr_empty = (wr_ptr_q == rd_ptr_q);
  assign ptr_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_rdy_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      assert (ptr_empty == empty_q);
      assert (ptr_full == full_q);
      in_rdy_q <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; reset discards contents by clearing the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  assign head = mem[rd_ptr_q[AW-1:0]];

  assign in_rdy      = in_rdy_q;
  assign out_vld     = !empty_q;
  assign out_data    = head[DATA_WIDTH-1:0];
  assign out_pc_pass = head[DATA_WIDTH];
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign overflow    = ovf_q;

endmodule
